// File: rtl/posit_encode_pipe.sv
// posit_encode_pipe: two-stage pipelined posit encoder.
// Takes a decoded posit value (sign, signed power-of-two scale, fraction below the
// hidden 1, zero/NaR flags) and packs it into an N-bit posit. Rounding is
// round-to-nearest-even, and results saturate at maxpos/minpos.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   in_sign, in_zero,     decoded operand: sign (1 = negative), zero flag,
//   in_nar, in_scale,     NaR flag, two's-complement scale (SW bits),
//   in_frac               fraction bits below the hidden 1, MSB first
//   out_valid / out_ready output handshake
//   out_posit             packed posit, two's complement for negative values
//
// Stage 1 builds the regime/exponent/fraction body. Stage 2 rounds, clamps and
// packs it. in_ready depends combinationally on out_ready only.
module posit_encode_pipe #(
    parameter int unsigned N  = 8,
    parameter int unsigned es = 3,
    localparam int unsigned Bs = $clog2(N),
    localparam int unsigned SW = Bs + es + 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic          in_zero,
    input  logic          in_nar,
    input  logic [SW-1:0] in_scale,
    input  logic [N-1:0]  in_frac,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_posit
);
    // Working width: terminator + exponent + fraction + room for the longest
    // unsaturated regime run. Bits below the kept 2N fold into a sticky bit.
    localparam int unsigned BW = 2 * N + es + 1;

    localparam logic [SW-1:0] KMAX       = SW'(N - 2);   // k >= KMAX saturates high
    localparam logic [SW-1:0] KMIN       = ~SW'(N - 2);  // -(N-1): k <= KMIN saturates low
    localparam logic [SW-1:0] KMAG_CLAMP = SW'(N - 3);
    localparam logic [SW-1:0] RUN_CLAMP  = SW'(N - 1);

    // Handshake and pipeline state
    logic           en1, en2;
    logic           v1_q, v2_q;
    logic           sign1_q, zero1_q, nar1_q, smax1_q, smin1_q, sticky1_q;
    logic [2*N-1:0] body1_q;
    logic [N-1:0]   posit_q;

    assign en2       = !v2_q || out_ready;
    assign en1       = !v1_q || en2;
    assign in_ready  = en1;
    assign out_valid = v2_q;
    assign out_posit = posit_q;

    // ---------------- Stage 1: regime construction ----------------
    logic [SW-1:0] k, kmag, run_len;
    logic          k_neg, sat_max, sat_min;
    logic [BW-1:0] tail_al, shifted, fill, body_full;

    assign k       = $unsigned($signed(in_scale) >>> es);
    assign k_neg   = k[SW-1];
    // Run length is k+1 ones for k >= 0, -k zeros for k < 0; ~k == -k-1.
    assign kmag    = k_neg ? ~k : k;
    // Clamp keeps the shifter small; any clamped value is saturated anyway.
    assign run_len = (kmag > KMAG_CLAMP) ? RUN_CLAMP : kmag + SW'(1);
    assign sat_max = !k_neg && (k >= KMAX);
    assign sat_min = k_neg && (k <= KMIN);

    // The regime terminator equals the sign of k (0 after ones, 1 after zeros).
    assign tail_al   = {k_neg, in_scale[es-1:0], in_frac, {N{1'b0}}};
    assign shifted   = tail_al >> run_len;
    assign fill      = ~({BW{1'b1}} >> run_len);
    assign body_full = k_neg ? shifted : (shifted | fill);

    // ---------------- Stage 2: round and pack ----------------
    logic [N-2:0] m, mag;
    logic         g, s, rnd;
    logic [N-1:0] sum, posit_d;

    assign m   = body1_q[2*N-1 -: N-1];
    assign g   = body1_q[N];
    assign s   = (|body1_q[N-1:0]) | sticky1_q;
    assign rnd = g & (s | m[0]);
    assign sum = {1'b0, m} + {{(N-1){1'b0}}, rnd};

    always_comb begin
        mag = sum[N-2:0];
        // A carry out of the magnitude would land on the NaR pattern.
        if (sum[N-1]) mag = '1;
        if (mag == '0) mag = {{(N-2){1'b0}}, 1'b1};
        if (smax1_q) begin
            mag = '1;
        end else if (smin1_q) begin
            mag = {{(N-2){1'b0}}, 1'b1};
        end
        posit_d = sign1_q ? -{1'b0, mag} : {1'b0, mag};
        if (nar1_q)  posit_d = {1'b1, {(N-1){1'b0}}};
        if (zero1_q) posit_d = '0;
    end

    // ---------------- State ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            sign1_q   <= 1'b0;
            zero1_q   <= 1'b0;
            nar1_q    <= 1'b0;
            smax1_q   <= 1'b0;
            smin1_q   <= 1'b0;
            sticky1_q <= 1'b0;
            body1_q   <= '0;
        end else if (en1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                sign1_q   <= in_sign;
                zero1_q   <= in_zero;
                nar1_q    <= in_nar;
                smax1_q   <= sat_max;
                smin1_q   <= sat_min;
                body1_q   <= body_full[BW-1 -: 2*N];
                sticky1_q <= |body_full[BW-2*N-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            posit_q <= '0;
        end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) posit_q <= posit_d;
        end
    end

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Self-checking bench for posit_encode_pipe (N=8, es=3). Expected values come
// from spec constants or from a bit-list posit model built from the scale.
module tb_posit_encode_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_sign, in_zero, in_nar;
    logic [7:0] in_scale, in_frac;
    logic       out_valid, out_ready;
    logic [7:0] out_posit;

    int n_pass  = 0;
    int n_total = 0;

    posit_encode_pipe #(.N(8), .es(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_zero   (in_zero),
        .in_nar    (in_nar),
        .in_scale  (in_scale),
        .in_frac   (in_frac),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_posit (out_posit)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         s;
        bit         z;
        bit         n;
        int         sc;
        logic [7:0] fr;
    } beat_t;

    // Reference: value = (-1)^s * 2^sc * 1.fr written out as a posit bit string.
    function automatic logic [7:0] model(input beat_t b);
        int k, e, mag, g, st;
        bit bits[$];
        if (b.z) return 8'h00;
        if (b.n) return 8'h80;
        k = (b.sc >= 0) ? b.sc / 8 : -((-b.sc + 7) / 8);
        e = b.sc - 8 * k;
        if (k >= 6) begin
            mag = 127;
        end else if (k <= -7) begin
            mag = 1;
        end else begin
            if (k >= 0) begin
                repeat (k + 1) bits.push_back(1'b1);
                bits.push_back(1'b0);
            end else begin
                repeat (-k) bits.push_back(1'b0);
                bits.push_back(1'b1);
            end
            for (int i = 2; i >= 0; i--) bits.push_back(((e >> i) & 1) != 0);
            for (int i = 7; i >= 0; i--) bits.push_back(b.fr[i] == 1'b1);
            mag = 0;
            for (int i = 0; i < 7; i++) mag = mag * 2 + (bits[i] ? 1 : 0);
            g  = bits[7] ? 1 : 0;
            st = 0;
            for (int i = 8; i < bits.size(); i++) if (bits[i]) st = 1;
            if (g == 1 && (st == 1 || (mag % 2) == 1)) mag++;
            if (mag > 127) mag = 127;
            if (mag == 0) mag = 1;
        end
        return b.s ? 8'(256 - mag) : 8'(mag);
    endfunction

    function automatic beat_t mk(input bit s, input bit z, input bit n, input int sc,
                                 input logic [7:0] fr);
        beat_t b;
        b.s = s; b.z = z; b.n = n; b.sc = sc; b.fr = fr;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        int r;
        r    = int'($urandom_range(0, 63));
        b.z  = (r == 0);
        b.n  = (r == 1);
        b.s  = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 3) == 0) b.sc = int'($urandom_range(0, 255)) - 128;
        else                            b.sc = int'($urandom_range(0, 110)) - 60;
        b.fr = 8'($urandom);
        return b;
    endfunction

    task automatic drive(input beat_t b);
        in_sign  = b.s;
        in_zero  = b.z;
        in_nar   = b.n;
        in_scale = 8'(b.sc);
        in_frac  = b.fr;
    endtask

    // Sends one beat with out_ready high; lat counts edges from the accepting
    // edge (1) to the edge after which out_valid is first seen.
    task automatic send_and_get(input beat_t b, output logic [7:0] got, output int lat,
                                output bit timeout);
        int guard;
        @(negedge clk);
        out_ready = 1'b1;
        drive(b);
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        timeout  = 1'b1;
        got      = 8'hxx;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                got     = out_posit;
                timeout = 1'b0;
                break;
            end
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(mk(0, 0, 0, 0, 8'h00));
        repeat (3) @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (out_posit !== 8'h00) $display("FAIL reset_out_posit: got %02h want 00", out_posit);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        beat_t      cs[3];
        logic [7:0] ex[3];
        logic [7:0] got;
        int         lat;
        bit         to;
        cs[0] = mk(0, 0, 0, 0, 8'h00); ex[0] = 8'h40;
        cs[1] = mk(0, 0, 0, 9, 8'h00); ex[1] = 8'h62;
        cs[2] = mk(1, 0, 0, 0, 8'h00); ex[2] = 8'hC0;
        for (int i = 0; i < 3; i++) begin
            send_and_get(cs[i], got, lat, to);
            n_total++;
            if (to || got !== ex[i])
                $display("FAIL basic_%0d: got %02h (timeout %0d) want %02h", i, got, to, ex[i]);
            else n_pass++;
            if (i == 0) begin
                n_total++;
                if (to || lat != 2) $display("FAIL latency: got %0d want 2", lat);
                else n_pass++;
            end
        end
    endtask

    task automatic test_specials();
        beat_t      cs[10];
        logic [7:0] ex[10];
        logic [7:0] got;
        int         lat;
        bit         to;
        cs[0] = mk(0, 1, 0, 5, 8'h33);    ex[0] = 8'h00;  // zero
        cs[1] = mk(1, 1, 1, 5, 8'h33);    ex[1] = 8'h00;  // zero beats NaR
        cs[2] = mk(0, 0, 1, -3, 8'h12);   ex[2] = 8'h80;  // NaR
        cs[3] = mk(0, 0, 0, 100, 8'h00);  ex[3] = 8'h7F;
        cs[4] = mk(1, 0, 0, 100, 8'h00);  ex[4] = 8'h81;
        cs[5] = mk(0, 0, 0, -100, 8'h00); ex[5] = 8'h01;
        cs[6] = mk(0, 0, 0, 48, 8'hFF);   ex[6] = 8'h7F;  // k = N-2 saturates
        cs[7] = mk(0, 0, 0, 47, 8'hFF);   ex[7] = 8'h7F;  // rounding must not reach NaR
        cs[8] = mk(0, 0, 0, -56, 8'h00);  ex[8] = 8'h01;  // k = -(N-1) saturates
        cs[9] = mk(0, 0, 0, -41, 8'h00);  ex[9] = 8'h02;  // k = -6 rounds up
        for (int i = 0; i < 10; i++) begin
            send_and_get(cs[i], got, lat, to);
            n_total++;
            if (to || got !== ex[i])
                $display("FAIL special_%0d: got %02h (timeout %0d) want %02h", i, got, to, ex[i]);
            else n_pass++;
        end
    endtask

    task automatic test_rounding();
        beat_t      cs[4];
        logic [7:0] ex[4];
        logic [7:0] got;
        int         lat;
        bit         to;
        cs[0] = mk(0, 0, 0, 0, 8'hA0); ex[0] = 8'h42;  // tie, stays even
        cs[1] = mk(0, 0, 0, 0, 8'hB0); ex[1] = 8'h43;
        cs[2] = mk(0, 0, 0, 0, 8'hE0); ex[2] = 8'h44;  // tie, carries into exponent
        cs[3] = mk(1, 0, 0, 0, 8'hB0); ex[3] = 8'hBD;
        for (int i = 0; i < 4; i++) begin
            send_and_get(cs[i], got, lat, to);
            n_total++;
            if (to || got !== ex[i])
                $display("FAIL round_%0d: got %02h (timeout %0d) want %02h", i, got, to, ex[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random_single();
        beat_t      b;
        logic [7:0] got, exp;
        int         lat;
        bit         to;
        for (int i = 0; i < 40; i++) begin
            b   = rand_beat();
            exp = model(b);
            send_and_get(b, got, lat, to);
            n_total++;
            if (to || got !== exp)
                $display("FAIL random_%0d: s=%0d sc=%0d fr=%02h got %02h want %02h",
                         i, b.s, b.sc, b.fr, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        beat_t      b[4];
        logic [7:0] q[$];
        logic [7:0] held, exp;
        bit         have_held, took;
        int         idx, accepted, unstable, got_n;
        for (int i = 0; i < 4; i++) b[i] = mk(i[0], 0, 0, 3 * i - 4, 8'(17 * i + 5));
        idx = 0; accepted = 0; unstable = 0; have_held = 0; held = 8'h00;
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(b[idx]);
            in_valid = 1'b1;
            if (out_valid) begin
                if (!have_held) begin
                    held      = out_posit;
                    have_held = 1'b1;
                end else if (out_posit !== held) begin
                    unstable++;
                end
            end
            took = in_ready;
            if (took) begin
                q.push_back(model(b[idx]));
                accepted++;
            end
            @(posedge clk);
            if (took && idx < 3) idx++;
            @(negedge clk);
        end
        n_total++;
        if (accepted != 2) $display("FAIL bp_accepted: got %0d want 2", accepted);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready);
        else n_pass++;
        n_total++;
        if (!have_held || unstable != 0 || out_posit !== held)
            $display("FAIL bp_stable: changes %0d held %02h now %02h", unstable, held, out_posit);
        else n_pass++;
        n_total++;
        if (held !== model(b[0])) $display("FAIL bp_held: got %02h want %02h", held, model(b[0]));
        else n_pass++;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got_n     = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin
                exp = (q.size() != 0) ? q.pop_front() : 8'hxx;
                n_total++;
                if (out_posit !== exp)
                    $display("FAIL bp_drain_%0d: got %02h want %02h", got_n, out_posit, exp);
                else n_pass++;
                got_n++;
            end
            @(negedge clk);
        end
        n_total++;
        if (got_n != 2) $display("FAIL bp_drain_count: got %0d want 2", got_n);
        else n_pass++;
    endtask

    task automatic test_throughput();
        logic [7:0] tq[$];
        int         first_c, last_c, got_n, bad;
        first_c = -1; last_c = -1; got_n = 0; bad = 0;
        out_ready = 1'b1;
        fork
            begin
                beat_t b;
                int    guard;
                for (int i = 0; i < 256; i++) begin
                    @(negedge clk);
                    b = rand_beat();
                    drive(b);
                    in_valid = 1'b1;
                    guard = 0;
                    while (!in_ready && guard < 20) begin
                        @(negedge clk);
                        guard++;
                    end
                    tq.push_back(model(b));
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                logic [7:0] exp;
                for (int c = 0; c < 800 && got_n < 256; c++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (first_c < 0) first_c = c;
                        last_c = c;
                        exp = (tq.size() != 0) ? tq.pop_front() : 8'hxx;
                        n_total++;
                        if (out_posit !== exp) begin
                            if (bad < 10)
                                $display("FAIL stream_%0d: got %02h want %02h",
                                         got_n, out_posit, exp);
                            bad++;
                        end else n_pass++;
                        got_n++;
                    end
                end
            end
        join
        n_total++;
        if (got_n != 256) $display("FAIL stream_count: got %0d want 256", got_n);
        else n_pass++;
        n_total++;
        if (first_c < 0 || last_c - first_c + 1 > 257)
            $display("FAIL stream_cycles: got %0d want <= 257", last_c - first_c + 1);
        else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        beat_t      a, b, c;
        logic [7:0] got;
        int         lat;
        bit         to;
        a = mk(0, 0, 0, 12, 8'h5A);
        b = mk(1, 0, 0, -9, 8'hC3);
        c = mk(0, 0, 0, 20, 8'h81);
        @(negedge clk);
        out_ready = 1'b1;
        drive(a);
        in_valid = 1'b1;
        @(negedge clk);
        drive(b);
        @(negedge clk);
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL mid_in_flight: got %b want 1", out_valid);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL mid_async_drop: got %b want 0", out_valid);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL mid_no_stale: got %b want 0", out_valid);
        else n_pass++;
        send_and_get(c, got, lat, to);
        n_total++;
        if (to || got !== model(c))
            $display("FAIL mid_first_after: got %02h (timeout %0d) want %02h", got, to, model(c));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_specials();
        test_rounding();
        test_random_single();
        test_backpressure();
        test_throughput();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
